// File: rtl/hamming_rx_deser.sv
// Serial Hamming(7,4) receiver: deserializes MSB-first codewords, corrects
// single data-bit errors and presents each word through a valid/ready holding register.
module hamming_rx_deser #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             sync,
  output logic [3:0]       out_data,
  output logic [3:0]       out_raw,
  output logic [2:0]       out_syndrome,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count
);

  function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6],
            c[1] ^ c[2] ^ c[5] ^ c[6],
            c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  // Parity-bit errors (syndromes 1, 2, 4) leave the data field untouched.
  function automatic logic [3:0] correct_data(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] f;
    f = c;
    case (s)
      3'd3:    f[2] = ~f[2];
      3'd5:    f[4] = ~f[4];
      3'd6:    f[5] = ~f[5];
      3'd7:    f[6] = ~f[6];
      default: f = c;
    endcase
    return {f[6], f[5], f[4], f[2]};
  endfunction

  logic [2:0]       cnt_q, cnt_d;
  logic [5:0]       shreg_q, shreg_d;
  logic [3:0]       data_q, data_d;
  logic [3:0]       raw_q, raw_d;
  logic [2:0]       syn_q, syn_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic       bit_accept;
  logic       word_load;
  logic [6:0] codeword;
  logic [2:0] syn_new;

  assign bit_ready  = !((cnt_q == 3'd6) && valid_q && !out_ready);
  assign bit_accept = bit_valid && bit_ready;
  assign word_load  = bit_accept && (cnt_q == 3'd6) && !sync;
  assign codeword   = {shreg_q, bit_in};
  assign syn_new    = calc_syndrome(codeword);

  // Next-state for the bit counter and shift register.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (sync) begin
      cnt_d   = 3'd0;
      shreg_d = 6'd0;
    end else if (bit_accept) begin
      if (cnt_q == 3'd6) begin
        cnt_d   = 3'd0;
        shreg_d = 6'd0;
      end else begin
        cnt_d   = cnt_q + 3'd1;
        shreg_d = {shreg_q[4:0], bit_in};
      end
    end else begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
    end
  end

  // Next-state for the holding register and error counter.
  always_comb begin
    data_d  = data_q;
    raw_d   = raw_q;
    syn_d   = syn_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (word_load) begin
      data_d  = correct_data(codeword, syn_new);
      raw_d   = {codeword[6], codeword[5], codeword[4], codeword[2]};
      syn_d   = syn_new;
      valid_d = 1'b1;
      if ((syn_new != 3'd0) && (err_q != {CNT_W{1'b1}})) begin
        err_d = err_q + CNT_W'(1);
      end else begin
        err_d = err_q;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      shreg_q <= 6'd0;
      data_q  <= 4'd0;
      raw_q   <= 4'd0;
      syn_q   <= 3'd0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      raw_q   <= raw_d;
      syn_q   <= syn_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_data     = data_q;
  assign out_raw      = raw_q;
  assign out_syndrome = syn_q;
  assign out_valid    = valid_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_hamming_rx_deser.sv
// Directed bench for hamming_rx_deser; a second instance with CNT_W=2 covers counter saturation.
module tb_hamming_rx_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       sync;
  logic       out_ready;
  logic       bit_ready;
  logic [3:0] out_data;
  logic [3:0] out_raw;
  logic [2:0] out_syndrome;
  logic       out_valid;
  logic [7:0] err_count;

  logic       bit_ready2;
  logic [3:0] out_data2;
  logic [3:0] out_raw2;
  logic [2:0] out_syndrome2;
  logic       out_valid2;
  logic [1:0] err_count2;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] CW_A = 7'b1010101;  // data 1011, clean
  localparam logic [6:0] CW_B = 7'b1000000;  // data 0000 with c6 flipped

  always #5 clk = ~clk;

  hamming_rx_deser #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sync(sync), .out_data(out_data), .out_raw(out_raw), .out_syndrome(out_syndrome),
    .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  hamming_rx_deser #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready2),
    .sync(sync), .out_data(out_data2), .out_raw(out_raw2), .out_syndrome(out_syndrome2),
    .out_valid(out_valid2), .out_ready(out_ready), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [6:0] cw);
    for (int i = 6; i >= 0; i--) send_bit(cw[i]);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] w;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sync = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_raw", out_raw, 0);
    chk("rst_syndrome", out_syndrome, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_bit_ready", bit_ready, 1);

    // Clean word, latency of one cycle from the last bit
    for (int i = 6; i >= 1; i--) begin
      send_bit(CW_A[i]);
      chk("clean_no_early_valid", out_valid, 0);
    end
    send_bit(CW_A[0]);
    chk("clean_valid", out_valid, 1);
    chk("clean_data", out_data, 4'b1011);
    chk("clean_raw", out_raw, 4'b1011);
    chk("clean_syndrome", out_syndrome, 0);
    chk("clean_err", err_count, 0);
    idle_cycle();
    chk("clean_valid_falls", out_valid, 0);

    // Single-bit errors in every position
    for (int i = 0; i < 7; i++) begin
      w = CW_A ^ (7'b0000001 << i);
      send_word(w);
      chk("serr_valid", out_valid, 1);
      chk("serr_syndrome", out_syndrome, i + 1);
      chk("serr_data", out_data, 4'b1011);
      chk("serr_raw", out_raw, {w[6], w[5], w[4], w[2]});
      chk("serr_err", err_count, i + 1);
    end
    chk("serr_err_sat2", err_count2, 3);
    idle_cycle();

    // Backpressure: two words back to back with consumer stalled
    out_ready = 1'b0;
    send_word(CW_A);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_data", out_data, 4'b1011);
    for (int i = 6; i >= 1; i--) send_bit(CW_B[i]);
    chk("bp_hold_data", out_data, 4'b1011);
    chk("bp_ready_low", bit_ready, 0);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = CW_B[0];
    @(posedge clk);
    #1;
    chk("bp_stall_valid", out_valid, 1);
    chk("bp_stall_data", out_data, 4'b1011);
    chk("bp_stall_syn", out_syndrome, 0);
    chk("bp_stall_ready", bit_ready, 0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", bit_ready, 1);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    chk("bp_b2b_valid", out_valid, 1);
    chk("bp_b2b_data", out_data, 4'b0000);
    chk("bp_b2b_raw", out_raw, 4'b1000);
    chk("bp_b2b_syn", out_syndrome, 7);
    chk("bp_b2b_err", err_count, 8);
    idle_cycle();
    chk("bp_valid_falls", out_valid, 0);

    // Sync mid-word discards the partial codeword
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    sync      = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sync      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b0);
      chk("sync_no_spurious", out_valid, 0);
    end
    send_bit(1'b0);
    chk("sync_valid", out_valid, 1);
    chk("sync_data", out_data, 4'b0000);
    chk("sync_raw", out_raw, 4'b0000);
    chk("sync_syn", out_syndrome, 0);
    chk("sync_err", err_count, 8);
    idle_cycle();

    // Reset mid-operation with a held word
    out_ready = 1'b0;
    send_word(CW_A);
    chk("rmid_held", out_valid, 1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_valid", out_valid, 0);
    chk("rmid_err", err_count, 0);
    chk("rmid_err2", err_count2, 0);
    chk("rmid_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rmid_bit_ready", bit_ready, 1);
    for (int i = 6; i >= 1; i--) begin
      send_bit(CW_B[i]);
      chk("rmid_no_early", out_valid, 0);
    end
    send_bit(CW_B[0]);
    chk("rmid_word_valid", out_valid, 1);
    chk("rmid_word_syn", out_syndrome, 7);
    chk("rmid_word_data", out_data, 4'b0000);
    chk("sat_err_1", err_count2, 1);

    // Saturation of the 2-bit counter
    send_word(CW_B);
    chk("sat_err_2", err_count2, 2);
    send_word(CW_B);
    chk("sat_err_3", err_count2, 3);
    send_word(CW_B);
    chk("sat_err_4", err_count2, 3);
    send_word(CW_B);
    chk("sat_err_5", err_count2, 3);
    chk("sat_err_wide", err_count, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_rx_deser.md
HAMMING_RX_DESER -- requirements
Module: hamming_rx_deser

Interface
REQ-001 Parameter CNT_W, default 8, width of the corrected-error counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 bit_in  input  1  serial codeword bit.
REQ-005 bit_valid  input  1  bit_in is offered this cycle.
REQ-006 bit_ready  output  1  block accepts bit_in this cycle; a bit transfers when bit_valid && bit_ready.
REQ-007 sync  input  1  frame realign: discard the partial codeword.
REQ-008 out_data  output  4  corrected data {c6,c5,c4,c2}.
REQ-009 out_raw  output  4  uncorrected data {c6,c5,c4,c2}.
REQ-010 out_syndrome  output  3  syndrome of the held codeword.
REQ-011 out_valid  output  1  holding register contains a codeword.
REQ-012 out_ready  input  1  consumer accepts; a codeword transfers when out_valid && out_ready.
REQ-013 err_count  output  CNT_W  saturating count of codewords with a nonzero syndrome.

Function
REQ-014 Bits SHALL arrive MSB first: the first accepted bit after reset, sync or frame completion is c6; the seventh is c0.
REQ-015 A 3-bit counter SHALL track accepted bits 0..6 and return to 0 on the cycle the seventh bit is accepted; it never holds a value above 6.
REQ-016 The completed codeword SHALL load the holding register on the edge the seventh bit is accepted; out_valid rises on that edge (latency of one cycle from the last bit).
REQ-017 Syndrome: s0=c0^c2^c4^c6, s1=c1^c2^c5^c6, s2=c3^c4^c5^c6; out_syndrome={s2,s1,s0}.
REQ-018 Correction: syndrome 3/5/6/7 inverts c2/c4/c5/c6 respectively in out_data; syndromes 1, 2 and 4 (parity-bit error) and 0 leave out_data equal to out_raw.
REQ-019 Syndrome and correction SHALL be registered with the codeword; outputs are stable while out_valid && !out_ready.
REQ-020 out_valid SHALL fall on the edge after a transfer, unless a new codeword loads on that same edge, in which case it stays high with the new contents (back-to-back, no bubble).
REQ-021 bit_ready SHALL be 0 only when the counter is 6 && out_valid && !out_ready; otherwise 1. Bits before the seventh are always accepted.
REQ-022 err_count SHALL increment by 1 on each load with a nonzero syndrome and saturate at 2^CNT_W-1.
REQ-023 sync SHALL clear the counter and shift register on the next edge; any bit accepted in the same cycle is discarded; the holding register, out_valid and err_count are unaffected.
REQ-024 bit_valid low SHALL freeze the counter and shift register; gaps of any length are allowed.
REQ-025 No transfer SHALL occur when bit_valid is low, regardless of bit_in.

Reset
REQ-026 With rst high at an edge: counter=0, shift register=0, out_valid=0, out_data=0, out_raw=0, out_syndrome=0, err_count=0.
REQ-027 rst SHALL take priority over sync, bit and output transfers; a partial codeword in flight is lost.
REQ-028 bit_ready SHALL be 1 in the cycle after reset.

Verification
REQ-029 Clean word: data 4'b1011 encoded c6..c0=1,0,1,0,1,0,1 sent with out_ready=1 -> out_data=1011, out_raw=1011, syndrome=0, out_valid one cycle after the 7th bit, err_count=0.
REQ-030 Single-bit errors: same word with each of c0..c6 flipped in turn -> syndrome equals position+1 (1..7), out_data=1011 every time, err_count=7.
REQ-031 Backpressure: out_ready=0, send two codewords continuously -> bit_ready drops at the second word's 7th bit, first word held stable; raise out_ready -> first word transfers, second loads on the same edge, out_valid stays 1.
REQ-032 Sync mid-word: send 4 bits, assert sync, then send full word 0000000 -> out_data=0000, syndrome=0, no spurious word from the discarded bits.
REQ-033 Saturation with CNT_W=2: send 5 single-error words -> err_count reads 1,2,3,3,3.
REQ-034 Reset mid-operation: rst after 3 bits while out_valid=1 -> next cycle out_valid=0, err_count=0, following 7 bits form one complete word.
